// File: rtl/pe_cube_pkg.sv
// Shared definitions for the PE cube tile: tile sequencer states, operand byte
// width and slice-offset helpers for the flattened data, weight and result buses.
// Latency: n/a (definitions only). Backpressure: n/a.
package pe_cube_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } tile_state_e;

  // Byte offset of array/lane entry `arr` in a one-byte-per-entry bus.
  function automatic int unsigned data_off(input int unsigned arr);
    return DATA_W * arr;
  endfunction

  // Offset of lane `lane` of array `arr` in a per-lane operand or result bus.
  function automatic int unsigned lane_off(input int unsigned arr,
                                           input int unsigned lane,
                                           input int unsigned block_num);
    return DATA_W * (block_num * arr + lane);
  endfunction

  // Offset of cube `cube`'s weight slice.
  function automatic int unsigned wgt_off(input int unsigned cube,
                                          input int unsigned block_num);
    return DATA_W * block_num * cube;
  endfunction

  // Offset of cube `cube`'s result slice.
  function automatic int unsigned res_off(input int unsigned cube,
                                          input int unsigned array_num,
                                          input int unsigned block_num);
    return DATA_W * array_num * block_num * cube;
  endfunction

endpackage

// File: rtl/pe_block.sv
// ARRAY_NUM x BLOCK_NUM multiply-accumulate array; lane (i,j) accumulates data(i,j) * weight(j).
// Latency: 2 cycles from iData/iWeight to settled oResult (product reg, then accumulator).
// Backpressure: none; all-zero operands leave the accumulators unchanged.
// Ports: iClearAcc zeroes product/accumulator regs; iCfsPassDataLeft[k] makes array k use
// array k+1's lane data; iCfsOutputLeftShift picks the LSB of the 8-bit output window.
module pe_block
  import pe_cube_pkg::*;
#(
  parameter int ARRAY_NUM = 3,
  parameter int BLOCK_NUM = 3
) (
  input  logic                                  iClk,
  input  logic                                  iRst,
  input  logic                                  iClearAcc,
  input  logic [ARRAY_NUM-2:0]                  iCfsPassDataLeft,
  input  logic [4:0]                            iCfsOutputLeftShift,
  input  logic [DATA_W*ARRAY_NUM*BLOCK_NUM-1:0] iData,
  input  logic [DATA_W*BLOCK_NUM-1:0]           iWeight,
  output logic [DATA_W*ARRAY_NUM*BLOCK_NUM-1:0] oResult
);

  localparam int ACC_BITS = 24;

  for (genvar gi = 0; gi < ARRAY_NUM; gi++) begin : g_arr
    for (genvar gj = 0; gj < BLOCK_NUM; gj++) begin : g_pe
      logic [DATA_W-1:0]   op;
      logic [2*DATA_W-1:0] prod_q;
      logic [ACC_BITS-1:0] acc_q;

      // The last array has no left-hand neighbour to borrow data from.
      if (gi < ARRAY_NUM - 1) begin : g_pass
        assign op = iCfsPassDataLeft[gi] ? iData[lane_off(gi + 1, gj, BLOCK_NUM) +: DATA_W]
                                         : iData[lane_off(gi, gj, BLOCK_NUM) +: DATA_W];
      end else begin : g_edge
        assign op = iData[lane_off(gi, gj, BLOCK_NUM) +: DATA_W];
      end

      always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
          prod_q <= '0;
          acc_q  <= '0;
        end else if (iClearAcc) begin
          prod_q <= '0;
          acc_q  <= '0;
        end else begin
          prod_q <= (2*DATA_W)'(op) * (2*DATA_W)'(iWeight[data_off(gj) +: DATA_W]);
          acc_q  <= acc_q + ACC_BITS'(prod_q);
        end
      end

      assign oResult[lane_off(gi, gj, BLOCK_NUM) +: DATA_W] = DATA_W'(acc_q >> iCfsOutputLeftShift);
    end
  end

endmodule

// File: rtl/pe_lane_mux.sv
// Per-array lane select: each lane takes data2_i when its mask bit is set, else data1_i.
// Latency: combinational. Backpressure: none.
// Ports: mask_i (one bit per lane), data1_i/data2_i (operand bytes), lane_o (one byte per lane).
module pe_lane_mux
  import pe_cube_pkg::*;
#(
  parameter int BLOCK_NUM = 3
) (
  input  logic [BLOCK_NUM-1:0]        mask_i,
  input  logic [DATA_W-1:0]           data1_i,
  input  logic [DATA_W-1:0]           data2_i,
  output logic [DATA_W*BLOCK_NUM-1:0] lane_o
);

  for (genvar j = 0; j < BLOCK_NUM; j++) begin : g_lane
    assign lane_o[data_off(j) +: DATA_W] = mask_i[j] ? data2_i : data1_i;
  end

endmodule

// File: rtl/pe_cube_tile.sv
// Tile sequencer around CUBE_NUM pe_blocks: start, stream iAccLen beats, drain, hold result.
// Latency: last accepted beat to oValid = PE_LATENCY + 2 cycles.
// Backpressure: oReady only in ACCUM; oResult/oValid held in OUT until iReady.
// Ports: iStart/iAccLen/iCfg* (start + config, latched on accept), iValid/oReady/iData1/iData2/
// iWeight (operand beats), oValid/iReady/oResult (result), oBusy (not IDLE), oErr (rejected start).
module pe_cube_tile
  import pe_cube_pkg::*;
#(
  parameter int CUBE_NUM   = 3,
  parameter int BLOCK_NUM  = 3,
  parameter int ARRAY_NUM  = 3,
  parameter int ACC_W      = 8,
  parameter int PE_LATENCY = 2
) (
  input  logic                                           iClk,
  input  logic                                           iRst,
  input  logic                                           iStart,
  input  logic [ACC_W-1:0]                               iAccLen,
  input  logic [ARRAY_NUM*BLOCK_NUM-1:0]                 iCfgSelMask,
  input  logic [ARRAY_NUM-2:0]                           iCfsPassDataLeft,
  input  logic [4:0]                                     iCfsOutputLeftShift,
  input  logic                                           iValid,
  output logic                                           oReady,
  input  logic [DATA_W*ARRAY_NUM-1:0]                    iData1,
  input  logic [DATA_W*ARRAY_NUM-1:0]                    iData2,
  input  logic [DATA_W*BLOCK_NUM*CUBE_NUM-1:0]           iWeight,
  output logic                                           oBusy,
  output logic                                           oErr,
  output logic                                           oValid,
  input  logic                                           iReady,
  output logic [DATA_W*ARRAY_NUM*BLOCK_NUM*CUBE_NUM-1:0] oResult
);

  localparam int LANE_W = DATA_W * ARRAY_NUM * BLOCK_NUM;
  localparam int WGT_W  = DATA_W * BLOCK_NUM;
  localparam int RES_W  = LANE_W * CUBE_NUM;
  localparam int MASK_W = ARRAY_NUM * BLOCK_NUM;
  localparam int DRN_W  = $clog2(PE_LATENCY + 1);

  tile_state_e state_q, state_d;

  logic [ACC_W-1:0]            len_q, len_d;
  logic [MASK_W-1:0]           mask_q, mask_d;
  logic [ARRAY_NUM-2:0]        pass_q, pass_d;
  logic [4:0]                  shift_q, shift_d;
  logic [ACC_W-1:0]            beat_cnt_q, beat_cnt_d;
  logic [DRN_W-1:0]            drn_cnt_q, drn_cnt_d;
  logic                        clr_q, clr_d;
  logic                        err_q, err_d;
  logic [LANE_W-1:0]           in_dat_q, in_dat_d;
  logic [WGT_W*CUBE_NUM-1:0]   in_wgt_q, in_wgt_d;
  logic [RES_W-1:0]            res_q, res_d;
  logic                        out_vld_q, out_vld_d;

  logic              start_ok, start_bad, beat_acc, last_beat, cap, out_done;
  logic [LANE_W-1:0] mux_dat;
  logic [RES_W-1:0]  pe_res;

  // Lane selection uses the mask latched at tile start, not the live input.
  for (genvar i = 0; i < ARRAY_NUM; i++) begin : g_mux
    pe_lane_mux #(.BLOCK_NUM(BLOCK_NUM)) u_mux (
      .mask_i  (mask_q[BLOCK_NUM*i +: BLOCK_NUM]),
      .data1_i (iData1[data_off(i) +: DATA_W]),
      .data2_i (iData2[data_off(i) +: DATA_W]),
      .lane_o  (mux_dat[lane_off(i, 0, BLOCK_NUM) +: WGT_W])
    );
  end

  // Accumulators are also held clear for the whole reset window.
  for (genvar c = 0; c < CUBE_NUM; c++) begin : g_cube
    pe_block #(.ARRAY_NUM(ARRAY_NUM), .BLOCK_NUM(BLOCK_NUM)) u_pe (
      .iClk                (iClk),
      .iRst                (iRst),
      .iClearAcc           (clr_q | ~iRst),
      .iCfsPassDataLeft    (pass_q),
      .iCfsOutputLeftShift (shift_q),
      .iData               (in_dat_q),
      .iWeight             (in_wgt_q[wgt_off(c, BLOCK_NUM) +: WGT_W]),
      .oResult             (pe_res[res_off(c, ARRAY_NUM, BLOCK_NUM) +: LANE_W])
    );
  end

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    beat_acc  = 1'b0;
    last_beat = 1'b0;
    cap       = 1'b0;
    out_done  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          if (iAccLen != '0) begin
            start_ok = 1'b1;
            state_d  = ST_ACCUM;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (iValid) begin
          beat_acc = 1'b1;
          if (beat_cnt_q == len_q - ACC_W'(1)) begin
            last_beat = 1'b1;
            state_d   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drn_cnt_q == '0) begin
          cap     = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (iReady) begin
          out_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    len_d      = len_q;
    mask_d     = mask_q;
    pass_d     = pass_q;
    shift_d    = shift_q;
    beat_cnt_d = beat_cnt_q;
    drn_cnt_d  = drn_cnt_q;
    clr_d      = start_ok;
    err_d      = start_bad;
    in_dat_d   = '0;  // idle cycles feed zeros so the accumulators hold
    in_wgt_d   = '0;
    res_d      = res_q;
    out_vld_d  = out_vld_q;

    if (start_ok) begin
      len_d      = iAccLen;
      mask_d     = iCfgSelMask;
      pass_d     = iCfsPassDataLeft;
      shift_d    = iCfsOutputLeftShift;
      beat_cnt_d = '0;
    end
    if (beat_acc) begin
      in_dat_d = mux_dat;
      in_wgt_d = iWeight;
      if (beat_cnt_q != '1) begin
        beat_cnt_d = beat_cnt_q + ACC_W'(1);
      end
    end
    if (last_beat) begin
      drn_cnt_d = DRN_W'(PE_LATENCY);
    end
    if (state_q == ST_DRAIN && drn_cnt_q != '0) begin
      drn_cnt_d = drn_cnt_q - DRN_W'(1);
    end
    if (cap) begin
      res_d     = pe_res;
      out_vld_d = 1'b1;
    end
    if (out_done) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      mask_q     <= '0;
      pass_q     <= '0;
      shift_q    <= '0;
      beat_cnt_q <= '0;
      drn_cnt_q  <= '0;
      clr_q      <= 1'b0;
      err_q      <= 1'b0;
      in_dat_q   <= '0;
      in_wgt_q   <= '0;
      res_q      <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      mask_q     <= mask_d;
      pass_q     <= pass_d;
      shift_q    <= shift_d;
      beat_cnt_q <= beat_cnt_d;
      drn_cnt_q  <= drn_cnt_d;
      clr_q      <= clr_d;
      err_q      <= err_d;
      in_dat_q   <= in_dat_d;
      in_wgt_q   <= in_wgt_d;
      res_q      <= res_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign oReady  = (state_q == ST_ACCUM);
  assign oBusy   = (state_q != ST_IDLE);
  assign oErr    = err_q;
  assign oValid  = out_vld_q;
  assign oResult = res_q;

endmodule

// File: tb/tb_pe_cube_tile.sv
// Bench for pe_cube_tile: randomized tiles checked against a sum-of-products reference model.
module tb_pe_cube_tile;
  localparam int CN = 3, BN = 3, AN = 3, AW = 8, PL = 2;
  localparam int RW = 8 * AN * BN * CN;

  logic          iClk = 1'b0;
  logic          iRst, iStart, iValid, iReady;
  logic [AW-1:0] iAccLen;
  logic [8:0]    iCfgSelMask;
  logic [1:0]    iCfsPassDataLeft;
  logic [4:0]    iCfsOutputLeftShift;
  logic [23:0]   iData1, iData2;
  logic [71:0]   iWeight;
  logic          oReady, oBusy, oErr, oValid;
  logic [RW-1:0] oResult;

  logic [23:0] d1_tab [256];
  logic [23:0] d2_tab [256];
  logic [71:0] w_tab  [256];

  int total = 0;
  int bad   = 0;

  pe_cube_tile #(.CUBE_NUM(CN), .BLOCK_NUM(BN), .ARRAY_NUM(AN), .ACC_W(AW), .PE_LATENCY(PL)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iAccLen(iAccLen), .iCfgSelMask(iCfgSelMask),
    .iCfsPassDataLeft(iCfsPassDataLeft), .iCfsOutputLeftShift(iCfsOutputLeftShift),
    .iValid(iValid), .oReady(oReady), .iData1(iData1), .iData2(iData2), .iWeight(iWeight),
    .oBusy(oBusy), .oErr(oErr), .oValid(oValid), .iReady(iReady), .oResult(oResult)
  );

  always #5 iClk = ~iClk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic fill_rand(input int n);
    for (int b = 0; b < n; b++) begin
      d1_tab[b] = 24'($urandom);
      d2_tab[b] = 24'($urandom);
      w_tab[b]  = 72'({$urandom, $urandom, $urandom});
    end
  endtask

  // Each lane sums selected-operand x lane-weight over the tile, wraps to 24 bits,
  // and reports the byte starting at bit `shift`.
  function automatic logic [RW-1:0] model(input int len, input logic [8:0] mask,
                                          input logic [1:0] pass, input logic [4:0] shift);
    longint unsigned acc [CN][AN][BN];
    longint unsigned lane [AN][BN];
    logic [RW-1:0] r;
    logic [23:0]   a;
    int src;
    for (int c = 0; c < CN; c++)
      for (int i = 0; i < AN; i++)
        for (int j = 0; j < BN; j++) acc[c][i][j] = 0;
    for (int b = 0; b < len; b++) begin
      for (int i = 0; i < AN; i++)
        for (int j = 0; j < BN; j++)
          lane[i][j] = mask[BN*i+j] ? longint'(d2_tab[b][8*i +: 8]) : longint'(d1_tab[b][8*i +: 8]);
      for (int c = 0; c < CN; c++)
        for (int i = 0; i < AN; i++)
          for (int j = 0; j < BN; j++) begin
            src = i;
            if (i < AN - 1) if (pass[i]) src = i + 1;
            acc[c][i][j] += lane[src][j] * longint'(w_tab[b][8*(BN*c+j) +: 8]);
          end
    end
    r = '0;
    for (int c = 0; c < CN; c++)
      for (int i = 0; i < AN; i++)
        for (int j = 0; j < BN; j++) begin
          a = 24'(acc[c][i][j]);
          r[8*(AN*BN*c + BN*i + j) +: 8] = 8'(a >> shift);
        end
    return r;
  endfunction

  task automatic run_tile(input int len, input logic [8:0] mask, input logic [1:0] pass,
                          input logic [4:0] shift, input int gap, input int hold,
                          input bit hs_start, output logic [RW-1:0] res);
    logic [RW-1:0] exp, held;
    int lat;
    bit stray_err, rdy_bad, hold_bad;
    exp = model(len, mask, pass, shift);
    iStart = 1; iAccLen = AW'(len); iCfgSelMask = mask;
    iCfsPassDataLeft = pass; iCfsOutputLeftShift = shift;
    tick;
    iStart = 0;
    check("busy_after_start", oBusy, 1);
    // Live config changes and a zero length must not affect the running tile.
    iCfgSelMask = 9'($urandom); iCfsPassDataLeft = 2'($urandom);
    iCfsOutputLeftShift = 5'($urandom); iAccLen = '0;
    stray_err = 0; rdy_bad = 0; hold_bad = 0;
    for (int b = 0; b < len; b++) begin
      for (int g = 0; g < gap; g++) begin
        iValid = 0; iStart = (g == 0);
        iData1 = 24'($urandom); iData2 = 24'($urandom);
        iWeight = 72'({$urandom, $urandom, $urandom});
        if (!oReady) rdy_bad = 1;
        tick;
        if (oErr) stray_err = 1;
      end
      iStart = 0; iValid = 1;
      iData1 = d1_tab[b]; iData2 = d2_tab[b]; iWeight = w_tab[b];
      if (!oReady) rdy_bad = 1;
      tick;
      if (oErr) stray_err = 1;
    end
    iValid = 0; iStart = 0;
    check("ready_in_accum", rdy_bad, 0);
    check("no_err_while_busy", stray_err, 0);
    check("ready_low_drain", oReady, 0);
    lat = 1;
    while (!oValid && lat < 20) begin
      tick;
      lat++;
    end
    check("last_beat_to_valid", lat, PL + 2);
    check("result", oResult, exp);
    held = oResult;
    for (int h = 0; h < hold; h++) begin
      tick;
      if (oResult !== held || !oValid || oReady) hold_bad = 1;
    end
    check("held_in_out", hold_bad, 0);
    iReady = 1;
    if (hs_start) begin
      iStart = 1; iAccLen = 1;
    end
    tick;
    iReady = 0; iStart = 0;
    check("valid_cleared", oValid, 0);
    check("idle_after_out", oBusy, 0);
    res = held;
  endtask

  initial begin
    logic [RW-1:0] r1, r2, cexp;
    logic [8:0] rm;
    logic [1:0] rp;
    logic [4:0] rs;
    iRst = 0; iStart = 0; iValid = 0; iReady = 0; iAccLen = '0;
    iCfgSelMask = '0; iCfsPassDataLeft = '0; iCfsOutputLeftShift = '0;
    iData1 = '0; iData2 = '0; iWeight = '0;
    tick; tick;
    iRst = 1;
    tick;
    check("reset_ready", oReady, 0);
    check("reset_busy", oBusy, 0);
    check("reset_err", oErr, 0);
    check("reset_valid", oValid, 0);
    check("reset_result", oResult, 0);

    // Basic tile: 4 beats of 1 x 2 per lane.
    for (int b = 0; b < 4; b++) begin
      d1_tab[b] = 24'h010101; d2_tab[b] = 24'($urandom); w_tab[b] = {9{8'h02}};
    end
    run_tile(4, 9'h000, 2'b00, 5'd0, 0, 5, 1'b0, r1);
    cexp = {27{8'h08}};
    check("basic_const", r1, cexp);

    // Lane select on array 1 only: lanes 0 and 2 from iData2.
    d1_tab[0] = 24'h030303; d2_tab[0] = 24'h050505; w_tab[0] = {9{8'h01}};
    run_tile(1, 9'b000_101_000, 2'b00, 5'd0, 0, 0, 1'b0, r1);
    cexp = '0;
    for (int c = 0; c < CN; c++)
      for (int i = 0; i < AN; i++)
        for (int j = 0; j < BN; j++)
          cexp[8*(AN*BN*c + BN*i + j) +: 8] = (i == 1 && j != 1) ? 8'h05 : 8'h03;
    check("mask_lanes", r1, cexp);

    // Rejected start.
    iStart = 1; iAccLen = '0;
    tick;
    iStart = 0;
    check("err_pulse", oErr, 1);
    check("err_stays_idle", oBusy, 0);
    tick;
    check("err_one_cycle", oErr, 0);

    // Bubbles must not change the result.
    fill_rand(3);
    rm = 9'($urandom); rp = 2'($urandom); rs = 5'($urandom_range(0, 4));
    run_tile(3, rm, rp, rs, 0, 1, 1'b0, r1);
    run_tile(3, rm, rp, rs, 2, 1, 1'b0, r2);
    check("bubble_same_result", r2, r1);

    // Reset in the middle of a 4-beat tile.
    fill_rand(4);
    iStart = 1; iAccLen = 8'd4; iCfgSelMask = '0; iCfsPassDataLeft = '0; iCfsOutputLeftShift = '0;
    tick;
    iStart = 0;
    for (int b = 0; b < 2; b++) begin
      iValid = 1; iData1 = d1_tab[b]; iData2 = d2_tab[b]; iWeight = w_tab[b];
      tick;
    end
    iValid = 1; iData1 = d1_tab[2]; iData2 = d2_tab[2]; iWeight = w_tab[2];
    #2;
    iRst = 0;
    #1;
    check("rst_mid_valid", oValid, 0);
    check("rst_mid_busy", oBusy, 0);
    check("rst_mid_ready", oReady, 0);
    check("rst_mid_result", oResult, 0);
    iValid = 0;
    tick;
    iRst = 1;
    tick;
    check("rst_release_idle", oBusy, 0);
    fill_rand(1);
    run_tile(1, 9'($urandom), 2'($urandom), 5'($urandom_range(0, 3)), 0, 0, 1'b0, r1);

    // Back-to-back: start during the handshake is ignored, the next one is accepted.
    fill_rand(5);
    run_tile(5, 9'($urandom), 2'($urandom), 5'($urandom_range(0, 6)), 1, 2, 1'b1, r1);
    fill_rand(2);
    run_tile(2, 9'($urandom), 2'($urandom), 5'($urandom_range(0, 6)), 0, 0, 1'b0, r1);

    // Longest tile the length field allows.
    fill_rand(255);
    run_tile(255, 9'($urandom), 2'($urandom), 5'd8, 0, 0, 1'b0, r1);

    // Random tiles.
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 12);
      fill_rand(n);
      run_tile(n, 9'($urandom), 2'($urandom), 5'($urandom_range(0, 7)),
               $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, r1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
